ram_wr_rd: RTL
==============

# ram_wr_rd

Key-driven single-port RAM exerciser: the write-side counterpart to the key-triggered ROM reader/display path. A debounced key press fills an internal 256x8 RAM with a known pattern, one word per clock. The block then reads the RAM back sequentially at a slow, parameterised rate. `rd_addr` and `rd_data` feed the existing six-digit seven-segment display driver.

## Interface
- `CNT_MAX`, default 999_999: debounce hold length in clocks (20 ms at 50 MHz).
- `RD_STEP`, default 9_999_999: clocks per read address (0.2 s at 50 MHz).
- `sys_clk` in, 1: system clock, 50 MHz; all logic on rising edge.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `key_in` in, 1: raw push-button, active-low, asynchronous to `sys_clk`.
- `wr_busy` out, 1: high while the fill is in progress.
- `rd_addr` out, 8: address of the word currently shown.
- `rd_data` out, 8: RAM word at `rd_addr`.
- `rd_valid` out, 1: high when `rd_data` corresponds to `rd_addr`.

## Operation
- **Key path**
  - `key_in` passes through a 2-FF synchroniser to give `key_s`.
  - The debounce counter clears while `key_s`=1 and increments while `key_s`=0, saturating at `CNT_MAX`.
  - `key_flag` pulses for one cycle when the counter equals `CNT_MAX`-1.
  - Result: exactly one pulse per press held at least `CNT_MAX` clocks. Bounces shorter than that produce none.
- **RAM**: 256x8 register array, one write port, one registered read port (1-cycle read latency).
- **FSM states**: IDLE, WRITE, READ, PAUSE.
  - IDLE + `key_flag` → WRITE, with `wr_addr`=0.
  - WRITE: each cycle writes `mem[wr_addr]` = 8'hFF − `wr_addr`, then `wr_addr`++. After writing address 255 → READ, with `rd_addr`=0 and the step counter cleared.
  - WRITE ignores `key_flag`.
  - READ: the step counter counts 0..`RD_STEP`-1. At terminal count, `rd_addr`++ (wraps 255→0).
  - READ + `key_flag` → PAUSE. The step counter and `rd_addr` hold.
  - PAUSE + `key_flag` → READ, resuming the count where it stopped.
  - A new fill happens only after reset.
- **Outputs**
  - `wr_busy` = (state==WRITE).
  - `rd_data` is registered from `mem[rd_addr]`.
  - `rd_valid` deasserts in the cycle `rd_addr` changes and reasserts one cycle later. It is 0 in IDLE and WRITE.
- **Arithmetic**: all address counters are 8-bit with natural wrap. The step counter is wide enough for `RD_STEP`-1 (24 bits at default).

## Timing
- **Reset values**
  - Outputs: `wr_busy`=0, `rd_addr`=0, `rd_data`=0, `rd_valid`=0.
  - Internal: state=IDLE, all counters 0, synchroniser FFs=1.
  - RAM contents are not reset.
- **Key latency**: press edge → `key_flag` at 2 (sync) + `CNT_MAX` clocks.
- **Fill**
  - `wr_busy` rises the cycle after `key_flag` and stays high exactly 256 cycles.
  - READ is entered the cycle after the address-255 write.
- **Readback**
  - `rd_data` = 8'hFF at READ entry + 1.
  - `rd_valid` rises at READ entry + 1.
  - Each later address is held `RD_STEP` cycles.
- **Simultaneous events**: a `key_flag` in the same cycle as the read step terminal count gives PAUSE priority. `rd_addr` does not advance.
- **Reset mid-operation**: asynchronous return to the reset values within the same cycle. A partial fill is abandoned. A reread after reset requires a new press and refill.

## Test plan
All scenarios use `CNT_MAX`=5, `RD_STEP`=4.
- **Reset**: `rst_n`=0 for 3 cycles → all outputs 0, state IDLE. Also assert `rst_n` during WRITE → `wr_busy` falls immediately and the block returns to IDLE.
- **Bounce rejection**: `key_in` low for 3 clocks, high 2, low 4 → no `key_flag`, `wr_busy` stays 0.
- **Fill**: `key_in` held low 10 clocks → one `key_flag`, then `wr_busy` high exactly 256 cycles. Internal `mem[0]`=FF, `mem[128]`=7F, `mem[255]`=00.
- **Readback**: after the fill → `rd_addr` 0,1,2… each held 4 cycles, `rd_data` = FF−`rd_addr` one cycle after each change. Run through the wrap 255→0 and check `rd_data`=FF again.
- **Pause/resume**: press during READ at `rd_addr`=5 → `rd_addr` stays 5 for ≥50 cycles. A second press resumes, reaching 6 after the remaining step count.
- **Key during WRITE**: press in mid-fill → ignored, fill completes in 256 cycles, READ starts normally.

Source files
------------

// File: rtl/ram_wr_rd.sv
// Key-driven RAM exerciser: a debounced press fills a 256x8 RAM with 8'hFF - addr,
// then the contents are read back one address every RD_STEP clocks for display.
module ram_wr_rd #(
    parameter int CNT_MAX = 999_999,
    parameter int RD_STEP = 9_999_999
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic       wr_busy,
    output logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rd_valid
);

    localparam int CNT_W  = $clog2(CNT_MAX + 1);
    localparam int STEP_W = (RD_STEP > 1) ? $clog2(RD_STEP) : 1;
    localparam logic [CNT_W-1:0]  CNT_TOP   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0]  CNT_ARM   = CNT_W'(CNT_MAX - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RD_STEP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    logic [1:0]        keySync_q;
    logic              keyS;
    logic [CNT_W-1:0]  debCnt_q, debCnt_d;
    logic              keyFlag_q, keyFlag_d;

    state_t            state_q, state_d;
    logic [7:0]        wrAddr_q, wrAddr_d;
    logic [7:0]        rdAddr_q, rdAddr_d;
    logic [STEP_W-1:0] stepCnt_q, stepCnt_d;
    logic              memWe;
    logic              readAdv;
    logic              readPhase;
    logic [7:0]        rdData_q;
    logic              rdValid_q;

    logic [7:0]        mem [0:255];

    assign keyS = keySync_q[1];

    // The flag fires on the clock where the count would reach CNT_MAX with the key still down.
    always_comb begin
        debCnt_d  = debCnt_q;
        keyFlag_d = 1'b0;
        if (keyS) begin
            debCnt_d = '0;
        end else if (debCnt_q != CNT_TOP) begin
            debCnt_d = debCnt_q + 1'b1;
        end
        keyFlag_d = !keyS && (debCnt_q == CNT_ARM);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            keySync_q <= 2'b11;
            debCnt_q  <= '0;
            keyFlag_q <= 1'b0;
        end else begin
            keySync_q <= {keySync_q[0], key_in};
            debCnt_q  <= debCnt_d;
            keyFlag_q <= keyFlag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wrAddr_d  = wrAddr_q;
        rdAddr_d  = rdAddr_q;
        stepCnt_d = stepCnt_q;
        memWe     = 1'b0;
        readAdv   = 1'b0;
        case (state_q)
            IDLE: begin
                if (keyFlag_q) begin
                    state_d  = WRITE;
                    wrAddr_d = '0;
                end
            end
            WRITE: begin
                memWe    = 1'b1;
                wrAddr_d = wrAddr_q + 8'd1;
                if (wrAddr_q == 8'hFF) begin
                    state_d   = READ;
                    rdAddr_d  = '0;
                    stepCnt_d = '0;
                end
            end
            READ: begin
                // A press on the terminal count wins: the address must not move into PAUSE.
                if (keyFlag_q) begin
                    state_d = PAUSE;
                end else if (stepCnt_q == STEP_LAST) begin
                    stepCnt_d = '0;
                    rdAddr_d  = rdAddr_q + 8'd1;
                    readAdv   = 1'b1;
                end else begin
                    stepCnt_d = stepCnt_q + 1'b1;
                end
            end
            PAUSE: begin
                if (keyFlag_q) begin
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wrAddr_q  <= '0;
            rdAddr_q  <= '0;
            stepCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wrAddr_q  <= wrAddr_d;
            rdAddr_q  <= rdAddr_d;
            stepCnt_q <= stepCnt_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (memWe) begin
            mem[wrAddr_q] <= 8'hFF - wrAddr_q;
        end
    end

    assign readPhase = (state_q == READ) || (state_q == PAUSE);

    // rd_data only tracks the RAM once the fill is done, so it never shows unwritten words.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
        end else begin
            if (readPhase) begin
                rdData_q <= mem[rdAddr_q];
            end
            rdValid_q <= readPhase && !readAdv;
        end
    end

    assign wr_busy  = (state_q == WRITE);
    assign rd_addr  = rdAddr_q;
    assign rd_data  = rdData_q;
    assign rd_valid = rdValid_q;

endmodule
